// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit full-duplex transfers, all four cpol/cpha modes,
// per-transfer sck divider and chip-select setup/hold framing.
// Optional build macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input (bit order select).
module spi_master_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] data_in,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              new_data,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned HALF_W = $clog2(2 * DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q;
    logic [BIT_W-1:0]    bit_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic                cpol_q;
    logic                cpha_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic                lsb_q;
`endif

    logic [DATA_W-1:0]   tx_load;
    logic [DATA_W-1:0]   rx_next;
    logic                half_end;
    logic                leading;

    assign busy     = (state_q != StIdle);
    assign half_end = (cnt_q == div_q);
    // Even-numbered half-periods end on a leading edge
    assign leading  = ~half_q[0];

    // Transmit word as loaded: LSB-first is handled by reversing it once at latch time
    always_comb begin
        tx_load = data_in;
`ifdef SPI_MASTER_LSB_FIRST_EN
        if (lsb_first) begin
            for (int i = 0; i < int'(DATA_W); i++) begin
                tx_load[i] = data_in[DATA_W-1-i];
            end
        end
`endif
    end

    // Receive shift: in at LSB normally, in at MSB for LSB-first so data_out keeps wire order
    always_comb begin
        rx_next = {rx_q[DATA_W-2:0], miso};
`ifdef SPI_MASTER_LSB_FIRST_EN
        if (lsb_q) begin
            rx_next = {miso, rx_q[DATA_W-1:1]};
        end
`endif
    end

    // Framing FSM with registered sck/mosi/cs_n/new_data/data_out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= '0;
            half_q   <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb_q    <= 1'b0;
`endif
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            new_data <= 1'b0;
            data_out <= '0;
        end else begin
            new_data <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cs_n   <= 1'b1;
                    sck    <= cpol;
                    cnt_q  <= '0;
                    half_q <= '0;
                    bit_q  <= '0;
                    if (start) begin
                        state_q <= StLead;
                        cs_n    <= 1'b0;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        div_q   <= div;
                        rx_q    <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
                        lsb_q   <= lsb_first;
`endif
                        // cpha=0 presents the first bit before the first edge
                        if (!cpha) begin
                            mosi <= tx_load[DATA_W-1];
                            tx_q <= {tx_load[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_q <= tx_load;
                        end
                    end
                end
                StLead: begin
                    if (half_end) begin
                        cnt_q   <= '0;
                        state_q <= StXfer;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StXfer: begin
                    if (half_end) begin
                        cnt_q  <= '0;
                        sck    <= ~sck;
                        half_q <= half_q + 1'b1;
                        if (leading == cpha_q) begin
                            // Shift-out edge; cpha=0 skips the trailing edge after the last
                            // sample (bit counter has wrapped back to 0)
                            if (cpha_q || (bit_q != '0)) begin
                                mosi <= tx_q[DATA_W-1];
                                tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            rx_q  <= rx_next;
                            bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
                        end
                        if (half_q == HALF_LAST) begin
                            half_q  <= '0;
                            state_q <= StTrail;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StTrail: begin
                    if (half_end) begin
                        cnt_q    <= '0;
                        state_q  <= StIdle;
                        cs_n     <= 1'b1;
                        new_data <= 1'b1;
                        data_out <= rx_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
